// File: rtl/l2_line_burst_adapter.sv
// Purpose: splits 256-bit L2 line reads/writes into 4-beat 64-bit memory bursts and reassembles read lines.
// Latency: request to resp pulse is 5 cycles minimum; each memory stall cycle (resp_i low) adds one.
// Backpressure: each beat waits for the memory resp_i strobe; the cache holds read_i/write_i until resp_o.
//
// Ports: clk/rst (sync, active-high); cache side line_i/line_o, address_i, read_i/write_i, resp_o, err_o;
//        memory side burst_i/burst_o, address_o, read_o/write_o, resp_i.
// Optional macro L2_ADAPTER_TIMEOUT_EN adds a watchdog that aborts a burst after TIMEOUT_CYCLES
// consecutive beat-less cycles (resp_o and err_o pulse together); otherwise err_o is tied low.

module l2_line_burst_adapter #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] line_i,
    output logic [255:0] line_o,
    input  logic [31:0]  address_i,
    input  logic         read_i,
    input  logic         write_i,
    output logic         resp_o,
    output logic         err_o,
    input  logic [63:0]  burst_i,
    output logic [63:0]  burst_o,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    input  logic         resp_i
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t       state;
    logic [1:0]   beat;
    logic [255:0] wbuf;
    logic [255:0] rbuf;
    logic         timeout;

    // Line addresses are 32-byte aligned, so the offset bits are never forwarded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address_i[4:0];

`ifdef L2_ADAPTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt;
    logic          busy;

    assign busy    = (state == S_READ) || (state == S_WRITE);
    assign timeout = busy && (idle_cnt == TW'(TIMEOUT_CYCLES));

    // Counts consecutive cycles without a beat; any beat or leaving the burst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
            err_o    <= 1'b0;
        end else begin
            err_o <= timeout;
            if (busy && !resp_i && !timeout) begin
                idle_cnt <= idle_cnt + TW'(1);
            end else begin
                idle_cnt <= '0;
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            beat      <= 2'd0;
            wbuf      <= '0;
            rbuf      <= '0;
            line_o    <= '0;
            burst_o   <= '0;
            address_o <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
        end else begin
            resp_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Read has priority; a simultaneous write is simply not accepted.
                    if (read_i) begin
                        address_o <= {address_i[31:5], 5'b0};
                        beat      <= 2'd0;
                        read_o    <= 1'b1;
                        state     <= S_READ;
                    end else if (write_i) begin
                        address_o <= {address_i[31:5], 5'b0};
                        beat      <= 2'd0;
                        wbuf      <= line_i;
                        burst_o   <= line_i[63:0];
                        write_o   <= 1'b1;
                        state     <= S_WRITE;
                    end
                end
                S_READ: begin
                    if (timeout) begin
                        read_o <= 1'b0;
                        resp_o <= 1'b1;
                        state  <= S_DONE;
                    end else if (resp_i) begin
                        rbuf[{beat, 6'b0} +: 64] <= burst_i;
                        if (beat == 2'd3) begin
                            // Publish the full line together with the final beat so it is
                            // visible in the DONE cycle.
                            line_o <= {burst_i, rbuf[191:0]};
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            beat <= beat + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (timeout) begin
                        write_o <= 1'b0;
                        burst_o <= '0;
                        resp_o  <= 1'b1;
                        state   <= S_DONE;
                    end else if (resp_i) begin
                        if (beat == 2'd3) begin
                            write_o <= 1'b0;
                            burst_o <= '0;
                            resp_o  <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            beat    <= beat + 2'd1;
                            burst_o <= wbuf[{beat + 2'd1, 6'b0} +: 64];
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_line_burst_adapter.sv
// Directed bench for l2_line_burst_adapter: reset/idle, read, stalled write,
// read/write collision, mid-burst reset, and watchdog (or its absence).
// Inputs change and outputs are sampled on the falling clock edge.

module tb_l2_line_burst_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic         err_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    l2_line_burst_adapter #(.TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .err_o     (err_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;

    logic [63:0]  dw [4];
    logic [63:0]  rb [4];
    logic [255:0] line_a;
    logic [255:0] line_b;
    int           wr_resp [8];
    int           wr_beat [8];
    int           resp_seen;

    initial begin
        dw[0] = 64'hD0D0_0000_0000_00D0;
        dw[1] = 64'hD1D1_1111_0000_00D1;
        dw[2] = 64'hD2D2_2222_0000_00D2;
        dw[3] = 64'hD3D3_3333_0000_00D3;
        rb[0] = 64'hA0A0_A0A0_0101_0101;
        rb[1] = 64'hA1A1_A1A1_0202_0202;
        rb[2] = 64'hA2A2_A2A2_0303_0303;
        rb[3] = 64'hA3A3_A3A3_0404_0404;
        line_a = {B4, B3, B2, B1};
        line_b = {rb[3], rb[2], rb[1], rb[0]};
        wr_resp = '{0, 0, 1, 0, 1, 1, 0, 1};
        wr_beat = '{0, 0, 0, 1, 1, 2, 3, 3};

        rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        burst_i = '0; resp_i = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset then idle with resp_i toggling: every output stays zero.
        for (int c = 0; c < 10; c++) begin
            check("idle_outs", {resp_o, err_o, read_o, write_o, address_o, burst_o, line_o}, '0);
            resp_i = ~resp_i;
            tick();
        end
        resp_i = 1'b0;

        // Read at 0x1234 with back-to-back beats in cycles 1..4.
        read_i = 1'b1; address_i = 32'h0000_1234;
        check("rd_c0_read_o", read_o, 1'b0);
        tick();
        check("rd_c1_read_o", read_o, 1'b1);
        check("rd_c1_address_o", address_o, 32'h0000_1220);
        resp_i = 1'b1; burst_i = B1; tick();
        check("rd_c2_resp_o", resp_o, 1'b0);
        burst_i = B2; tick();
        burst_i = B3; tick();
        check("rd_c4_address_o", address_o, 32'h0000_1220);
        burst_i = B4; tick();
        check("rd_c5_resp_o", resp_o, 1'b1);
        check("rd_c5_err_o", err_o, 1'b0);
        check("rd_c5_read_o", read_o, 1'b0);
        check("rd_c5_line_o", line_o, line_a);
        resp_i = 1'b0; read_i = 1'b0; burst_i = '0;
        tick();
        check("rd_c6_resp_o", resp_o, 1'b0);
        check("rd_c6_line_o", line_o, line_a);

        // Write with memory accepting only in cycles 2, 4, 5, 7.
        write_i = 1'b1; line_i = {dw[3], dw[2], dw[1], dw[0]}; address_i = 32'h0000_4040;
        resp_i = 1'b0;
        tick();
        for (int c = 1; c < 8; c++) begin
            check("wr_write_o", write_o, 1'b1);
            check("wr_read_o", read_o, 1'b0);
            check("wr_burst_o", burst_o, dw[wr_beat[c]]);
            check("wr_resp_o_early", resp_o, 1'b0);
            resp_i = (wr_resp[c] != 0);
            tick();
        end
        check("wr_c8_resp_o", resp_o, 1'b1);
        check("wr_c8_write_o", write_o, 1'b0);
        check("wr_c8_address_o", address_o, 32'h0000_4040);
        check("wr_c8_line_o", line_o, line_a);
        resp_i = 1'b0; write_i = 1'b0;
        tick();

        // Read and write requested together: read wins.
        read_i = 1'b1; write_i = 1'b1; address_i = 32'hDEAD_BEEF;
        line_i = {4{64'hFFFF_0000_FFFF_0000}};
        tick();
        for (int c = 1; c < 5; c++) begin
            check("rw_read_o", read_o, 1'b1);
            check("rw_write_o", write_o, 1'b0);
            check("rw_address_o", address_o, 32'hDEAD_BEE0);
            resp_i = 1'b1; burst_i = rb[c-1];
            tick();
        end
        check("rw_c5_resp_o", resp_o, 1'b1);
        check("rw_c5_write_o", write_o, 1'b0);
        check("rw_c5_line_o", line_o, line_b);
        resp_i = 1'b0; read_i = 1'b0; write_i = 1'b0;
        tick();

        // Reset after two beats of a read discards the partial line.
        read_i = 1'b1; address_i = 32'h0000_8000;
        tick();
        resp_i = 1'b1; burst_i = B1; tick();
        burst_i = B2; tick();
        rst = 1'b1; resp_i = 1'b0; read_i = 1'b0;
        tick();
        check("rst_read_o", read_o, 1'b0);
        check("rst_resp_o", resp_o, 1'b0);
        check("rst_line_o", line_o, 256'h0);
        check("rst_address_o", address_o, 32'h0);
        rst = 1'b0;
        resp_seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_o) resp_seen++;
            tick();
        end
        check("rst_no_resp", resp_seen, 0);

        // A following read completes normally.
        read_i = 1'b1; address_i = 32'h0000_9010;
        tick();
        check("post_rst_read_o", read_o, 1'b1);
        check("post_rst_address_o", address_o, 32'h0000_9000);
        resp_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            burst_i = rb[c];
            tick();
        end
        check("post_rst_resp_o", resp_o, 1'b1);
        check("post_rst_line_o", line_o, line_b);
        resp_i = 1'b0; read_i = 1'b0;
        tick();

        // Read that memory never answers.
        read_i = 1'b1; address_i = 32'h0000_0100;
        tick();
`ifdef L2_ADAPTER_TIMEOUT_EN
        for (int c = 1; c < 10; c++) begin
            check("to_wait_resp_o", resp_o, 1'b0);
            tick();
        end
        check("to_c10_resp_o", resp_o, 1'b1);
        check("to_c10_err_o", err_o, 1'b1);
        check("to_c10_line_o", line_o, line_b);
        read_i = 1'b0;
        tick();
        check("to_c11_err_o", err_o, 1'b0);
`else
        resp_seen = 0;
        for (int c = 1; c <= 100; c++) begin
            if (resp_o) resp_seen++;
            tick();
        end
        check("no_to_resp", resp_seen, 0);
        check("no_to_err_o", err_o, 1'b0);
        check("no_to_read_o", read_o, 1'b1);
        read_i = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l2_line_burst_adapter.md
# l2_line_burst_adapter

Converts whole 256-bit cache-line transfers from the L2 cache datapath into 4-beat, 64-bit bursts on the physical-memory bus, and the reverse. Sits directly downstream of the 2-way L2 cache datapath: it takes that block's `pmem_address`/`pmem_wdata` and returns `pmem_rdata`. It is a pure transfer engine with a small FSM and beat counter; it performs no caching decisions.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1023: watchdog limit in cycles without a memory beat; used only with the macro below.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `line_i`  in  256  line to write; sampled when a write is accepted.
- `line_o`  out  256  last fully read line.
- `address_i`  in  32  line address from cache.
- `read_i`  in  1  cache line-read request, level, held until `resp_o`.
- `write_i`  in  1  cache line-write request, level, held until `resp_o`.
- `resp_o`  out  1  one-cycle completion pulse to cache.
- `err_o`  out  1  one-cycle pulse with `resp_o` when the watchdog aborts.
- `burst_i`  in  64  read beat from memory.
- `burst_o`  out  64  write beat to memory.
- `address_o`  out  32  burst address, low 5 bits forced to 0.
- `read_o`  out  1  memory burst-read request.
- `write_o`  out  1  memory burst-write request.
- `resp_i`  in  1  memory beat-valid/accept strobe.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - `read_i`=1: latch `{address_i[31:5],5'b0}` into `address_o`, clear beat count, go to READ.
  - Else `write_i`=1: also latch `line_i` into the write buffer, then go to WRITE.
  - Both high: read wins. Write is not accepted until the cache re-requests.
- READ:
  - `read_o`=1.
  - Each cycle with `resp_i`=1: store `burst_i` into line bits [64k+63:64k], where k is the beat count, then k++.
  - Beat with k=3: go to DONE.
  - Cycles with `resp_i`=0: stall, no state change.
- WRITE:
  - `write_o`=1 and `burst_o` = buffer bits [64k+63:64k].
  - Each `resp_i`=1 means memory accepted beat k; advance k.
  - k=3 accepted: go to DONE.
- DONE:
  - `resp_o`=1 for exactly this cycle, then go to IDLE.
  - After a read, `line_o` shows the new line during this cycle.
- `line_o` changes only when a read completes. Writes and aborts leave it unchanged.
- `read_o` and `write_o` are never both high. `address_o` is stable for the whole burst.
- Beat count is 2 bits and is only compared against 3, never wrapped past it.
- `resp_i` seen in IDLE or DONE is ignored.
- The cache must drop its request in the cycle after `resp_o`. A request still high in the IDLE cycle that follows is treated as a new transfer.

## Timing
- Reset values: `resp_o`, `err_o`, `read_o`, `write_o` = 0. `address_o`, `burst_o`, `line_o` = 0. State IDLE, beat count 0.
- Reset asserted mid-burst: next edge forces IDLE and clears all outputs. No `resp_o` is issued, and the partially filled line is discarded (`line_o` = 0).
- Request high in cycle 0 means `read_o`/`write_o` is high in cycle 1.
- `resp_i` may be high in the same cycle `read_o`/`write_o` first rises.
- With back-to-back beats in cycles 1–4, `resp_o` is high in cycle 5. Minimum request-to-`resp_o` latency is 5 cycles; each stall cycle adds 1.
- Minimum spacing between transfer starts is 6 cycles (5 + one DONE→IDLE cycle).

## Configuration
- Macro `L2_ADAPTER_TIMEOUT_EN`, when defined:
  - A counter in READ/WRITE increments on each cycle with `resp_i`=0 and clears on each beat.
  - Reaching `TIMEOUT_CYCLES` forces DONE with `resp_o`=1 and `err_o`=1.
  - `line_o` is unchanged.
- When undefined:
  - No counter is built and `err_o` is tied to 0.
  - The FSM waits indefinitely for beats.

## Test plan
- Reset then idle: all outputs 0 for 10 cycles, with `resp_i` toggling, which has no effect.
- Read at `address_i`=0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 in cycles 1–4 → `address_o`=0x0000_1220, `resp_o` in cycle 5, `line_o`={0x44..,0x33..,0x22..,0x11..}.
- Write `line_i`={D3,D2,D1,D0}, `resp_i` high only in cycles 2, 4, 5, 7 → `burst_o` shows D0..D3 in order, advancing only on those cycles; `resp_o` in cycle 8; `line_o` unchanged.
- `read_i` and `write_i` both high in IDLE → `read_o`=1, `write_o`=0 throughout, and the write buffer is not loaded.
- `rst` asserted after beat 2 of a read → IDLE next cycle, `resp_o` never pulses, `line_o`=0. A following read completes normally.
- With `L2_ADAPTER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8: read with no `resp_i` → `resp_o`=`err_o`=1 in cycle 10; without the macro, no `resp_o` within 100 cycles.
